// File: rtl/amux_pkg.sv
// Shared types for the analog mux scan sequencer.
package amux_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_SETTLE,
    S_CONVERT,
    S_NEXT
  } state_e;

  // Channel index width for the default four-channel bank; the top derives its own from NCH.
  localparam int NCH_DEF = 4;
  localparam int CHW     = $clog2(NCH_DEF);

endpackage

// File: rtl/amux_next_ch.sv
// Finds the lowest set mask bit at or above from_i; from_i may be NCH (nothing left).
module amux_next_ch #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] mask_i,
  input  logic [CHW:0]   from_i,
  output logic [CHW-1:0] idx_o,
  output logic           found_o
);

  // Descending scan so the lowest qualifying bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i] && ((CHW+1)'(i) >= from_i)) begin
        idx_o   = CHW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amux_scan_sequencer.sv
// Scans enabled analog mux channels with break-before-make, settle delay and ADC handshake.
module amux_scan_sequencer
  import amux_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 12,
  parameter int CW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    continuous,
  input  logic                    stop,
  input  logic [NCH-1:0]          ch_mask,
  input  logic [CW-1:0]           bbm_cycles,
  input  logic [CW-1:0]           settle_cycles,
  output logic [NCH-1:0]          mux_sel,
  output logic                    adc_req,
  input  logic                    adc_done,
  input  logic [DW-1:0]           adc_data,
  output logic                    res_valid,
  output logic [DW-1:0]           res_data,
  output logic [$clog2(NCH)-1:0]  res_ch,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CHN = $clog2(NCH);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int NW  = (TW > CW) ? TW : CW;

  state_e          state_q, state_d;
  logic [CHN-1:0]  ch_q, ch_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [CW-1:0]   bbm_q, bbm_d, set_q, set_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            stop_q, stop_d;
  logic [NCH-1:0]  mux_q, mux_d;
  logic            req_q, req_d, rv_q, rv_d, terr_q, terr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [CHN-1:0]  rch_q, rch_d;

  logic [NCH-1:0]  first_mask;
  logic [CHN:0]    adv_from;
  logic [CHN-1:0]  first_idx, adv_idx;
  logic            first_found, adv_found, stop_eff;

  // A zero count still yields one cycle in the phase.
  function automatic logic [NW-1:0] ld_cnt(input logic [CW-1:0] v);
    return (v == '0) ? '0 : NW'(v) - NW'(1);
  endfunction

  assign first_mask = (state_q == S_IDLE) ? ch_mask : mask_q;
  assign adv_from   = {1'b0, ch_q} + (CHN+1)'(1);
  assign stop_eff   = stop_q | stop;

  amux_next_ch #(.NCH(NCH), .CHW(CHN)) u_first (
    .mask_i(first_mask), .from_i({(CHN+1){1'b0}}), .idx_o(first_idx), .found_o(first_found)
  );

  amux_next_ch #(.NCH(NCH), .CHW(CHN)) u_adv (
    .mask_i(mask_q), .from_i(adv_from), .idx_o(adv_idx), .found_o(adv_found)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    bbm_d   = bbm_q;
    set_d   = set_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    terr_d  = terr_q;
    rdata_d = rdata_q;
    rch_d   = rch_q;
    rv_d    = 1'b0;
    if (stop && state_q != S_IDLE) stop_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start && first_found) begin
          mask_d  = ch_mask;
          bbm_d   = bbm_cycles;
          set_d   = settle_cycles;
          terr_d  = 1'b0;
          ch_d    = first_idx;
          cnt_d   = ld_cnt(bbm_cycles);
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        if (cnt_q == '0) begin
          cnt_d   = ld_cnt(set_q);
          state_d = S_SETTLE;
        end else cnt_d = cnt_q - NW'(1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = NW'(TIMEOUT - 1);
          state_d = S_CONVERT;
        end else cnt_d = cnt_q - NW'(1);
      end
      S_CONVERT: begin
        if (adc_done) begin
          rdata_d = adc_data;
          rch_d   = ch_q;
          rv_d    = 1'b1;
          state_d = S_NEXT;
        end else if (cnt_q == '0) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else cnt_d = cnt_q - NW'(1);
      end
      S_NEXT: begin
        if (adv_found) begin
          if (stop_eff) state_d = S_IDLE;
          else begin
            ch_d    = adv_idx;
            cnt_d   = ld_cnt(bbm_q);
            state_d = S_BREAK;
          end
        end else if (continuous && !stop_eff) begin
          ch_d    = first_idx;
          cnt_d   = ld_cnt(bbm_q);
          state_d = S_BREAK;
        end else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) stop_d = 1'b0;
    // Select follows the next state so the pin is a clean flop output; NEXT holds it.
    mux_d = '0;
    if (state_d == S_SETTLE || state_d == S_CONVERT || state_d == S_NEXT) mux_d[ch_d] = 1'b1;
    req_d = (state_d == S_CONVERT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      mask_q  <= '0;
      bbm_q   <= '0;
      set_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      mux_q   <= '0;
      req_q   <= 1'b0;
      rv_q    <= 1'b0;
      terr_q  <= 1'b0;
      rdata_q <= '0;
      rch_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      bbm_q   <= bbm_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      mux_q   <= mux_d;
      req_q   <= req_d;
      rv_q    <= rv_d;
      terr_q  <= terr_d;
      rdata_q <= rdata_d;
      rch_q   <= rch_d;
    end
  end

  assign mux_sel     = mux_q;
  assign adc_req     = req_q;
  assign res_valid   = rv_q;
  assign res_data    = rdata_q;
  assign res_ch      = rch_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_amux_scan_sequencer.sv
// Directed bench for amux_scan_sequencer: latency table plus multi-cycle corner sequences.
module tb_amux_scan_sequencer;

  logic        clk, resetn, start, continuous, stop;
  logic [3:0]  ch_mask, mux_sel;
  logic [7:0]  bbm_cycles, settle_cycles;
  logic        adc_req, adc_done, res_valid, busy, timeout_err;
  logic [11:0] adc_data, res_data;
  logic [1:0]  res_ch;

  logic        resp_en, resp_done, spur_done;
  int          resp_delay;
  logic [11:0] resp_data, spur_data;
  logic [11:0] data_q[$];

  int checks = 0, errors = 0;

  // Monitor state (written only by the monitor)
  int          viol = 0, req_rise = 0, sel_rise = 0;
  logic [3:0]  prev_sel = '0;
  logic        prev_req = 1'b0;
  logic        log_en = 1'b0;
  int          rch_q[$];
  logic [11:0] rdat_q[$];
  logic [3:0]  sel_log[$];

  assign adc_done = resp_done | spur_done;
  assign adc_data = resp_done ? resp_data : spur_data;

  amux_scan_sequencer #(.NCH(4), .DW(12), .CW(8), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .continuous(continuous), .stop(stop),
    .ch_mask(ch_mask), .bbm_cycles(bbm_cycles), .settle_cycles(settle_cycles),
    .mux_sel(mux_sel), .adc_req(adc_req), .adc_done(adc_done), .adc_data(adc_data),
    .res_valid(res_valid), .res_data(res_data), .res_ch(res_ch), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC model: pulses adc_done on the resp_delay-th cycle of adc_req.
  initial begin
    int rcnt;
    rcnt = 0;
    resp_done = 1'b0;
    resp_data = '0;
    forever begin
      @(posedge clk); #1;
      resp_done = 1'b0;
      if (resp_en && adc_req && resetn) begin
        rcnt++;
        if (rcnt == resp_delay) begin
          resp_done = 1'b1;
          resp_data = (data_q.size() > 0) ? data_q.pop_front() : 12'h000;
        end
      end else rcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if ($countones(mux_sel) > 1) viol <= viol + 1;
      if (prev_sel != 4'b0 && mux_sel != 4'b0 && mux_sel != prev_sel) viol <= viol + 1;
      if (prev_sel == 4'b0 && mux_sel != 4'b0) sel_rise <= sel_rise + 1;
      if (adc_req && !prev_req) req_rise <= req_rise + 1;
      if (res_valid) begin
        rch_q.push_back(int'(res_ch));
        rdat_q.push_back(res_data);
      end
      if (log_en) sel_log.push_back(mux_sel);
    end
    prev_sel <= mux_sel;
    prev_req <= adc_req;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setup(input logic [3:0] m, input int b, input int s);
    ch_mask = m;
    bbm_cycles = 8'(b);
    settle_cycles = 8'(s);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 400) begin step(); k++; end
    chk(name, int'(busy), 0);
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!adc_req && k < 200) begin step(); k++; end
    chk(name, int'(adc_req), 1);
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          b, s, k;
    logic [11:0] data;
    int          exp_ch, exp_lat;
  } vec_t;
  vec_t tv[5];

  initial begin
    int n, rb, qb, sb, lb;
    int rv[$], rl[$];

    // latency = 1 + max(b,1) + max(s,1) + k + 1
    tv[0] = '{4'b0001, 2, 3, 5, 12'h0A5, 0, 12};
    tv[1] = '{4'b0010, 0, 0, 1, 12'h123, 1, 5};
    tv[2] = '{4'b1000, 1, 1, 3, 12'hFFF, 3, 7};
    tv[3] = '{4'b0100, 4, 0, 2, 12'h800, 2, 9};
    tv[4] = '{4'b0110, 0, 2, 4, 12'h456, 1, 9};

    resetn = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0;
    setup(4'b0, 0, 0);
    resp_en = 1'b1; resp_delay = 1; spur_done = 1'b0; spur_data = '0;
    #12;
    chk("rst_mux", int'(mux_sel), 0);
    chk("rst_req", int'(adc_req), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_data", int'(res_data), 0);
    chk("rst_ch", int'(res_ch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_terr", int'(timeout_err), 0);
    #11 resetn = 1'b1;
    step();

    // Empty mask: start is ignored
    qb = req_rise;
    setup(4'b0000, 1, 1);
    pulse_start();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || mux_sel != 4'b0 || adc_req) n++;
      step();
    end
    chk("mask0_activity", n, 0);
    chk("mask0_req", req_rise - qb, 0);

    // Two-channel scan, select sequence and results
    resp_delay = 5;
    data_q.push_back(12'h0A5); data_q.push_back(12'h5A0);
    rb = rch_q.size();
    setup(4'b0101, 2, 3);
    pulse_start();
    lb = sel_log.size();
    log_en = 1'b1;
    wait_idle("t1_idle");
    step();
    log_en = 1'b0;
    for (int i = lb; i < sel_log.size(); i++) begin
      if (rv.size() > 0 && int'(sel_log[i]) == rv[rv.size()-1]) rl[rl.size()-1]++;
      else begin rv.push_back(int'(sel_log[i])); rl.push_back(1); end
    end
    chk("t1_runs", (rv.size() >= 5) ? 1 : 0, 1);
    if (rv.size() >= 5) begin
      chk("t1_run0_val", rv[0], 0); chk("t1_run0_len", rl[0], 2);
      chk("t1_run1_val", rv[1], 1); chk("t1_run1_len", rl[1], 9);
      chk("t1_run2_val", rv[2], 0); chk("t1_run2_len", rl[2], 2);
      chk("t1_run3_val", rv[3], 4); chk("t1_run3_len", rl[3], 9);
      chk("t1_run4_val", rv[4], 0);
    end
    chk("t1_nres", rch_q.size() - rb, 2);
    if (rch_q.size() - rb == 2) begin
      chk("t1_ch0", rch_q[rb], 0);   chk("t1_d0", int'(rdat_q[rb]), 'h0A5);
      chk("t1_ch1", rch_q[rb+1], 2); chk("t1_d1", int'(rdat_q[rb+1]), 'h5A0);
    end

    // Latency table
    foreach (tv[v]) begin
      resp_delay = tv[v].k;
      data_q.push_back(tv[v].data);
      if ($countones(tv[v].mask) > 1) data_q.push_back(12'h000);
      setup(tv[v].mask, tv[v].b, tv[v].s);
      start = 1'b1; n = 1;
      step(); n++;
      start = 1'b0;
      while (!res_valid && n < 100) begin step(); n++; end
      chk($sformatf("lat%0d", v), n, tv[v].exp_lat);
      chk($sformatf("ch%0d", v), int'(res_ch), tv[v].exp_ch);
      chk($sformatf("data%0d", v), int'(res_data), int'(tv[v].data));
      wait_idle($sformatf("idle%0d", v));
    end

    // Continuous single channel, stop during second conversion
    resp_delay = 3;
    data_q.push_back(12'h111); data_q.push_back(12'h222);
    rb = rch_q.size(); qb = req_rise; sb = sel_rise;
    continuous = 1'b1;
    setup(4'b1000, 1, 1);
    pulse_start();
    n = 0;
    while (rch_q.size() == rb && n < 100) begin step(); n++; end
    chk("t2_first_res", rch_q.size() - rb, 1);
    wait_req("t2_req2");
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle("t2_idle");
    repeat (3) step();
    continuous = 1'b0;
    chk("t2_nres", rch_q.size() - rb, 2);
    if (rch_q.size() - rb == 2) begin
      chk("t2_ch", rch_q[rb+1], 3);
      chk("t2_data", int'(rdat_q[rb+1]), 'h222);
    end
    chk("t2_reqs", req_rise - qb, 2);
    chk("t2_breaks", sel_rise - sb, 2);

    // Timeout on both channels, scan proceeds
    resp_en = 1'b0;
    rb = rch_q.size();
    setup(4'b0011, 1, 1);
    pulse_start();
    wait_req("t4_req1");
    n = 0;
    while (adc_req && n < 100) begin step(); n++; end
    chk("t4_req_len", n, 16);
    chk("t4_terr", int'(timeout_err), 1);
    wait_req("t4_req2");
    chk("t4_sel2", int'(mux_sel), 'b0010);
    wait_idle("t4_idle");
    chk("t4_nres", rch_q.size() - rb, 0);
    chk("t4_terr_sticky", int'(timeout_err), 1);
    resp_en = 1'b1; resp_delay = 2;
    data_q.push_back(12'h007);
    setup(4'b0001, 1, 1);
    pulse_start();
    chk("t4_terr_clr", int'(timeout_err), 0);
    wait_idle("t4_idle2");

    // Spurious adc_done in IDLE and SETTLE
    rb = rch_q.size();
    spur_data = 12'hBAD;
    spur_done = 1'b1; step(); spur_done = 1'b0;
    step();
    chk("t6_idle_nres", rch_q.size() - rb, 0);
    chk("t6_idle_busy", int'(busy), 0);
    data_q.push_back(12'h3C3);
    setup(4'b0100, 2, 4);
    pulse_start();
    n = 0;
    while (mux_sel == 4'b0 && n < 50) begin step(); n++; end
    chk("t6_in_settle", (mux_sel != 4'b0 && !adc_req) ? 1 : 0, 1);
    spur_done = 1'b1; step(); spur_done = 1'b0;
    wait_idle("t6_idle");
    step();
    chk("t6_nres", rch_q.size() - rb, 1);
    if (rch_q.size() - rb == 1) begin
      chk("t6_data", int'(rdat_q[rb]), 'h3C3);
      chk("t6_ch", rch_q[rb], 2);
    end

    // Asynchronous reset mid-conversion, then a late adc_done
    resp_en = 1'b0;
    setup(4'b0001, 1, 1);
    pulse_start();
    wait_req("t5_req");
    #2 resetn = 1'b0;
    #1;
    chk("t5_mux", int'(mux_sel), 0);
    chk("t5_req", int'(adc_req), 0);
    chk("t5_busy", int'(busy), 0);
    #10 resetn = 1'b1;
    rb = rch_q.size();
    step();
    spur_done = 1'b1; step(); spur_done = 1'b0;
    repeat (3) step();
    chk("t5_nres", rch_q.size() - rb, 0);
    chk("t5_busy_after", int'(busy), 0);

    chk("mux_onehot_bbm", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amux_scan_sequencer.md
Name: amux_scan_sequencer

Overview:
Digital controller for a bank of analog 2:1 and N:1 muxes feeding the on-chip ADC. It generates the 1.8V select lines with break-before-make switching. It waits a programmable analog settling time, then handshakes one conversion with the ADC and tags the result with its channel number. It sits between the housekeeping/SPI register block and the analog mux select inputs and the ADC control port.

Parameters:
NCH, 4, number of analog channels; one select line per channel; 2..16
DW, 12, ADC result width
CW, 8, width of the break and settle cycle-count registers
TIMEOUT, 1023, cycles to wait for adc_done before aborting a conversion

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin a scan
continuous  input  1  1 = restart scan after last channel until stop
stop  input  1  one-cycle pulse; end scan after current conversion
ch_mask  input  NCH  enabled channels; sampled at scan start
bbm_cycles  input  CW  break-before-make gap (all selects low); sampled at scan start
settle_cycles  input  CW  settle time after select asserted; sampled at scan start
mux_sel  output  NCH  one-hot select to analog muxes; never two bits high
adc_req  output  1  conversion request to ADC
adc_done  input  1  ADC conversion complete, one-cycle pulse
adc_data  input  DW  ADC result, valid with adc_done
res_valid  output  1  one-cycle pulse; result available
res_data  output  DW  captured adc_data
res_ch  output  $clog2(NCH)  channel of res_data
busy  output  1  high in any state except IDLE
timeout_err  output  1  sticky; set on conversion timeout; cleared by start

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state IDLE. mux_sel=0, adc_req=0, res_valid=0, res_data=0, res_ch=0, busy=0, timeout_err=0.
- States: IDLE, BREAK, SETTLE, CONVERT, NEXT.
- IDLE: on start with ch_mask!=0, latch ch_mask, bbm_cycles and settle_cycles, clear timeout_err, point to the lowest set mask bit, go to BREAK. start with ch_mask==0 is ignored; stay IDLE, busy stays 0.
- BREAK: mux_sel=0 for max(bbm_cycles,1) cycles, then go to SETTLE.
- SETTLE: mux_sel=one-hot(current ch) from the first SETTLE cycle. Hold settle_cycles cycles; 0 means one cycle. Then go to CONVERT.
- CONVERT: adc_req=1 with mux_sel held. On adc_done: capture adc_data into res_data and ch into res_ch. Pulse res_valid the next cycle, drop adc_req, go to NEXT.
- CONVERT timeout: TIMEOUT cycles without adc_done sets timeout_err, drops adc_req and goes to NEXT with no res_valid.
- adc_done outside CONVERT is ignored.
- NEXT: advance to the next higher set bit of the latched mask.
  - If none remain and (continuous=1 and no stop pending), wrap to the lowest set bit and go to BREAK.
  - If none remain otherwise, mux_sel=0 and go to IDLE.
  - If a next bit exists and stop is pending, go to IDLE.
  - If a next bit exists and no stop is pending, go to BREAK.
- Every channel change passes through BREAK, including wrap.
- A single-channel mask in continuous mode still passes through BREAK each round.
- stop pulse in any busy state sets stop_pending; cleared on entering IDLE.
- start while busy is ignored.
- stop and start in the same cycle in IDLE: start wins; stop_pending is cleared.
- Latency for a single enabled channel from start pulse to res_valid: 1 + max(bbm,1) + max(settle,1) + (cycles to adc_done) + 1.
- mux_sel is registered: glitch-free and never multi-hot.

Decomposition:
- Shared package amux_pkg: state enum type, and localparam CHW=$clog2(NCH).
- Submodule amux_next_ch (combinational): given mask and current index, returns next set index and a found flag. Used for both first-channel and advance lookup.
- Down-counter for BREAK, SETTLE and timeout is shared and stays inline.

Test Plan:
1. NCH=4, mask=4'b0101, bbm=2, settle=3, single scan, ADC responds 5 cycles after req with data 0x0A5 then 0x5A0.
   Required: mux_sel sequence 0000(2 cycles) → 0001 → 0000(2) → 0100. res_valid twice with (ch0,0x0A5) then (ch2,0x5A0). Returns to IDLE with busy=0.
2. Continuous mode, mask=4'b1000; stop pulsed during the second conversion.
   Required: second result delivered, then IDLE. BREAK occurs before each round. No third adc_req.
3. mask=0, start pulsed.
   Required: busy stays 0, mux_sel=0, no adc_req.
4. adc_done never asserted, TIMEOUT=16.
   Required: adc_req drops after 16 cycles, timeout_err=1, no res_valid, scan proceeds to the next channel. A later start clears timeout_err.
5. resetn asserted low mid-CONVERT.
   Required: mux_sel, adc_req and busy go to 0 immediately (asynchronously). A late adc_done after release produces no res_valid.
6. Inject spurious adc_done in IDLE/SETTLE, and check mux_sel with a one-hot assertion every cycle.
   Required: spurious adc_done ignored; no multi-hot mux_sel ever; no direct channel-to-channel transition without an all-zero cycle.
